// File: rtl/jtframe_lfbuf_ddr_xfer.sv
// DDR3 burst engine below the line-frame-buffer line stage: writes a finished line
// to DDR and clears it, and reads a line of the opposite bank into the screen buffer.
module jtframe_lfbuf_ddr_xfer #(
  parameter int unsigned HW   = 9,
  parameter int unsigned VW   = 8,
  parameter logic [28:0] BASE = 29'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame,
  input  logic          wr_req,
  input  logic [VW-1:0] wr_line,
  input  logic          rd_req,
  input  logic [VW-1:0] rd_line,
  output logic          wr_done,
  output logic          rd_done,
  output logic [HW-3:0] fb_addr,
  input  logic [63:0]   fb_din,
  output logic          fb_we,
  output logic [HW-3:0] scr_addr,
  output logic [63:0]   scr_data,
  output logic          scr_we,
  output logic          ddram_clk,
  input  logic          ddram_busy,
  output logic [7:0]    ddram_burstcnt,
  output logic [28:0]   ddram_addr,
  input  logic [63:0]   ddram_dout,
  input  logic          ddram_dout_ready,
  output logic          ddram_rd,
  output logic [63:0]   ddram_din,
  output logic [7:0]    ddram_be,
  output logic          ddram_we,
  input  logic [7:0]    st_addr,
  output logic [7:0]    st_dout
);

  localparam int unsigned AW = HW - 2;
  localparam int unsigned NW = 1 << AW;
  localparam int unsigned LW = 1 + VW + AW;
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_FILL = 3'd3;
  localparam logic [2:0] ST_WR_BEAT = 3'd4;
  localparam logic [2:0] ST_CLR     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [VW-1:0] rd_line_q, rd_line_d, wr_line_q, wr_line_d;
  logic          rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          fill_ph_q, fill_ph_d;
  logic          nxt_vld_q, nxt_vld_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] scr_addr_q, scr_addr_d;
  logic [63:0]   scr_data_q, scr_data_d;
  logic          scr_we_q, scr_we_d;
  logic          wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic [28:0]   ddram_addr_q, ddram_addr_d;
  logic          ddram_rd_q, ddram_rd_d, ddram_we_q, ddram_we_d;
  logic [63:0]   ddram_din_q, ddram_din_d;
  logic [7:0]    stall_q, stall_d;
  logic [7:0]    st_dout_q, st_dout_d;
  logic          rd_clr, wr_clr;
  logic [LW-1:0] rd_off, wr_off;
  logic [28:0]   rd_base, wr_base;

  // Line base addresses from the latched bank/line
  assign rd_off  = {rd_bank_q, rd_line_q, {AW{1'b0}}};
  assign wr_off  = {wr_bank_q, wr_line_q, {AW{1'b0}}};
  assign rd_base = BASE + 29'(rd_off);
  assign wr_base = BASE + 29'(wr_off);

  always_comb begin
    state_d      = state_q;
    rd_pend_d    = rd_pend_q;
    wr_pend_d    = wr_pend_q;
    rd_line_d    = rd_line_q;
    wr_line_d    = wr_line_q;
    rd_bank_d    = rd_bank_q;
    wr_bank_d    = wr_bank_q;
    cnt_d        = cnt_q;
    fill_ph_d    = fill_ph_q;
    nxt_vld_d    = nxt_vld_q;
    fb_addr_d    = fb_addr_q;
    fb_we_d      = 1'b0;
    scr_addr_d   = scr_addr_q;
    scr_data_d   = scr_data_q;
    scr_we_d     = 1'b0;
    wr_done_d    = 1'b0;
    rd_done_d    = 1'b0;
    ddram_addr_d = ddram_addr_q;
    ddram_rd_d   = ddram_rd_q;
    ddram_we_d   = ddram_we_q;
    ddram_din_d  = ddram_din_q;
    stall_d      = stall_q;
    st_dout_d    = 8'd0;
    rd_clr       = 1'b0;
    wr_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rd_pend_q) begin
          ddram_addr_d = rd_base;
          ddram_rd_d   = 1'b1;
          state_d      = ST_RD_REQ;
        end else if (wr_pend_q) begin
          ddram_addr_d = wr_base;
          fb_addr_d    = '0;
          fill_ph_d    = 1'b0;
          state_d      = ST_WR_FILL;
        end
      end
      ST_RD_REQ: begin
        if (!ddram_busy) begin
          ddram_rd_d = 1'b0;
          state_d    = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (ddram_dout_ready) begin
          scr_we_d   = 1'b1;
          scr_data_d = ddram_dout;
          scr_addr_d = cnt_q;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            rd_done_d = 1'b1;
            rd_clr    = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      // First cycle presents the address, second captures the line-buffer word
      ST_WR_FILL: begin
        fill_ph_d = 1'b1;
        if (fill_ph_q) begin
          ddram_din_d = fb_din;
          ddram_we_d  = 1'b1;
          fb_addr_d   = cnt_q + 1'b1;
          nxt_vld_d   = 1'b0;
          fill_ph_d   = 1'b0;
          state_d     = ST_WR_BEAT;
        end
      end
      // nxt_vld_q: fb_din already holds word cnt+1, so a stalled beat can chain without a gap
      ST_WR_BEAT: begin
        if (!ddram_busy) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            ddram_we_d = 1'b0;
            cnt_d      = '0;
            fb_addr_d  = '0;
            fb_we_d    = 1'b1;
            state_d    = ST_CLR;
          end else if (nxt_vld_q) begin
            ddram_din_d = fb_din;
            fb_addr_d   = cnt_q + AW'(2);
            nxt_vld_d   = 1'b0;
          end else begin
            ddram_we_d = 1'b0;
            fill_ph_d  = 1'b1;
            state_d    = ST_WR_FILL;
          end
        end else begin
          nxt_vld_d = 1'b1;
        end
      end
      ST_CLR: begin
        if (cnt_q == LAST) begin
          wr_done_d = 1'b1;
          wr_clr    = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          fb_we_d   = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          fb_addr_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request arriving on the clearing cycle stays queued
    if (rd_clr) rd_pend_d = 1'b0;
    if (wr_clr) wr_pend_d = 1'b0;
    if (rd_req) begin
      rd_pend_d = 1'b1;
      rd_line_d = rd_line;
      rd_bank_d = ~frame;
    end
    if (wr_req) begin
      wr_pend_d = 1'b1;
      wr_line_d = wr_line;
      wr_bank_d = frame;
    end

    if ((ddram_we_q || ddram_rd_q) && ddram_busy && (stall_q != 8'hFF))
      stall_d = stall_q + 8'd1;

    case (st_addr)
      8'd0:    st_dout_d = {5'd0, state_q};
      8'd1:    st_dout_d = 8'(wr_line_q);
      8'd2:    st_dout_d = 8'(rd_line_q);
      8'd3:    st_dout_d = stall_q;
      default: st_dout_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_pend_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_line_q    <= '0;
      wr_line_q    <= '0;
      rd_bank_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
      cnt_q        <= '0;
      fill_ph_q    <= 1'b0;
      nxt_vld_q    <= 1'b0;
      fb_addr_q    <= '0;
      fb_we_q      <= 1'b0;
      scr_addr_q   <= '0;
      scr_data_q   <= '0;
      scr_we_q     <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      ddram_addr_q <= '0;
      ddram_rd_q   <= 1'b0;
      ddram_we_q   <= 1'b0;
      ddram_din_q  <= '0;
      stall_q      <= 8'd0;
      st_dout_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_pend_d;
      wr_pend_q    <= wr_pend_d;
      rd_line_q    <= rd_line_d;
      wr_line_q    <= wr_line_d;
      rd_bank_q    <= rd_bank_d;
      wr_bank_q    <= wr_bank_d;
      cnt_q        <= cnt_d;
      fill_ph_q    <= fill_ph_d;
      nxt_vld_q    <= nxt_vld_d;
      fb_addr_q    <= fb_addr_d;
      fb_we_q      <= fb_we_d;
      scr_addr_q   <= scr_addr_d;
      scr_data_q   <= scr_data_d;
      scr_we_q     <= scr_we_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      ddram_addr_q <= ddram_addr_d;
      ddram_rd_q   <= ddram_rd_d;
      ddram_we_q   <= ddram_we_d;
      ddram_din_q  <= ddram_din_d;
      stall_q      <= stall_d;
      st_dout_q    <= st_dout_d;
    end
  end

  assign wr_done        = wr_done_q;
  assign rd_done        = rd_done_q;
  assign fb_addr        = fb_addr_q;
  assign fb_we          = fb_we_q;
  assign scr_addr       = scr_addr_q;
  assign scr_data       = scr_data_q;
  assign scr_we         = scr_we_q;
  assign ddram_clk      = clk;
  assign ddram_burstcnt = 8'(NW);
  assign ddram_addr     = ddram_addr_q;
  assign ddram_rd       = ddram_rd_q;
  assign ddram_din      = ddram_din_q;
  assign ddram_be       = 8'hFF;
  assign ddram_we       = ddram_we_q;
  assign st_dout        = st_dout_q;

endmodule

// File: tb/tb_jtframe_lfbuf_ddr_xfer.sv
// Directed/randomized bench for jtframe_lfbuf_ddr_xfer with a line-buffer model
// and transaction-level expectations for DDR bursts, clears and screen writes.
module tb_jtframe_lfbuf_ddr_xfer;

  localparam int NW = 128;
  localparam logic [28:0] BASE_T = 29'h0100000;

  logic        clk = 1'b0;
  logic        rst, frame, wr_req, rd_req;
  logic [7:0]  wr_line, rd_line;
  logic        wr_done, rd_done;
  logic [6:0]  fb_addr, scr_addr;
  logic [63:0] fb_din, scr_data;
  logic        fb_we, scr_we;
  logic        ddram_clk, ddram_busy, ddram_dout_ready, ddram_rd, ddram_we;
  logic [7:0]  ddram_burstcnt, ddram_be, st_addr, st_dout;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_dout, ddram_din;

  int ncmp = 0, nfail = 0, cyc = 0, stalls = 0, we_cycles = 0;
  logic [63:0] mem [NW];

  jtframe_lfbuf_ddr_xfer #(.HW(9), .VW(8), .BASE(BASE_T)) dut (
    .clk(clk), .rst(rst), .frame(frame),
    .wr_req(wr_req), .wr_line(wr_line), .rd_req(rd_req), .rd_line(rd_line),
    .wr_done(wr_done), .rd_done(rd_done),
    .fb_addr(fb_addr), .fb_din(fb_din), .fb_we(fb_we),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_we(scr_we),
    .ddram_clk(ddram_clk), .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt),
    .ddram_addr(ddram_addr), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .ddram_rd(ddram_rd), .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_we(ddram_we),
    .st_addr(st_addr), .st_dout(st_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: line-buffer RAM (1-cycle read latency, clear writes) and stall monitor
  task automatic step();
    logic [6:0] a;
    logic       clr;
    a   = fb_addr;
    clr = fb_we;
    if (ddram_we) we_cycles++;
    if (rst) stalls = 0;
    else if ((ddram_we || ddram_rd) && ddram_busy && stalls < 255) stalls++;
    @(posedge clk); #1;
    fb_din = mem[a];
    if (clr) mem[a] = '0;
    cyc++;
  endtask

  function automatic logic [28:0] exp_addr(input logic bank, input int line);
    return BASE_T + 29'((bank ? 32768 : 0) + line * NW);
  endfunction

  task automatic fill_mem(input logic [15:0] salt);
    for (int i = 0; i < NW; i++) mem[i] = {4{16'(i) ^ salt}};
  endtask

  task automatic read_status(input logic [7:0] sel, input string tag, input logic [7:0] exp);
    st_addr = sel;
    step();
    check(tag, 64'(st_dout), 64'(exp));
  endtask

  task automatic do_write(input int line, input logic fr, input bit toggle, input bit issue,
                          input bit timed);
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int addr_bad, hold_bad, clr_bad, nclr, data_bad, nonzero, t0;
    bit done, prev_stall;
    logic [63:0] prev_din;
    addr_bad = 0; hold_bad = 0; clr_bad = 0; nclr = 0; data_bad = 0; nonzero = 0;
    done = 0; prev_stall = 0; prev_din = '0;
    for (int i = 0; i < NW; i++) exp_q.push_back(mem[i]);
    t0 = cyc;
    if (issue) begin
      frame = fr; wr_line = 8'(line); wr_req = 1'b1;
      step();
      wr_req = 1'b0;
    end
    for (int c = 0; c < 2000 && !done; c++) begin
      ddram_busy = toggle ? ~ddram_busy : 1'b0;
      if (prev_stall && (!ddram_we || ddram_din !== prev_din)) hold_bad++;
      if (ddram_we && ddram_addr !== exp_addr(fr, line)) addr_bad++;
      if (ddram_we && !ddram_busy) got_q.push_back(ddram_din);
      prev_stall = ddram_we && ddram_busy;
      prev_din   = ddram_din;
      if (fb_we) begin
        if (fb_addr !== 7'(nclr) || ddram_we || got_q.size() != NW) clr_bad++;
        nclr++;
      end
      if (wr_done) done = 1;
      else step();
    end
    ddram_busy = 1'b0;
    check("wr_done_seen", 64'(done), 64'(1));
    check("wr_beats", 64'(got_q.size()), 64'(NW));
    for (int i = 0; i < NW; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) data_bad++;
    check("wr_beat_data", 64'(data_bad), 64'(0));
    check("wr_addr", 64'(addr_bad), 64'(0));
    check("wr_din_hold", 64'(hold_bad), 64'(0));
    check("clr_count", 64'(nclr), 64'(NW));
    check("clr_order", 64'(clr_bad), 64'(0));
    for (int i = 0; i < NW; i++) if (mem[i] !== '0) nonzero++;
    check("line_cleared", 64'(nonzero), 64'(0));
    if (timed) check("wr_time_ok", 64'(cyc - t0 <= 4 * NW + 8), 64'(1));
    step();
    check("wr_done_pulse", 64'(wr_done), 64'(0));
  endtask

  task automatic read_request(input int line, input logic fr, input bit issue);
    bit acc;
    logic [28:0] a_seen;
    acc = 0; a_seen = '0;
    if (issue) begin
      frame = fr; rd_line = 8'(line); rd_req = 1'b1;
      step();
      rd_req = 1'b0;
    end
    for (int g = 0; g < 100 && !acc; g++) begin
      if (ddram_rd) begin
        ddram_busy = 1'($urandom_range(0, 1));
        acc    = !ddram_busy;
        a_seen = ddram_addr;
      end else ddram_busy = 1'b0;
      step();
    end
    ddram_busy = 1'b0;
    check("rd_accepted", 64'(acc), 64'(1));
    check("rd_addr", 64'(a_seen), 64'(exp_addr(~fr, line)));
    check("rd_drop", 64'(ddram_rd), 64'(0));
  endtask

  // Feed n words with random gaps; expect_out selects echo vs. silence on the screen side
  task automatic feed_words(input int n, input int k0, input bit expect_out);
    int bad, done_bad, extra, gap;
    logic [63:0] w;
    bad = 0; done_bad = 0; extra = 0;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        ddram_dout_ready = 1'b0;
        step();
        if (scr_we || rd_done) extra++;
      end
      w = {$urandom, $urandom};
      ddram_dout = w; ddram_dout_ready = 1'b1;
      step();
      ddram_dout_ready = 1'b0;
      if (expect_out) begin
        if (!scr_we || scr_addr !== 7'(k0 + k) || scr_data !== w) bad++;
        if (rd_done !== (k0 + k == NW - 1)) done_bad++;
      end else if (scr_we || rd_done) extra++;
    end
    if (expect_out) begin
      check("scr_echo", 64'(bad), 64'(0));
      check("rd_done_timing", 64'(done_bad), 64'(0));
    end
    check("scr_quiet", 64'(extra), 64'(0));
  endtask

  task automatic read_tail();
    step();
    check("rd_done_pulse", 64'(rd_done), 64'(0));
    check("scr_we_after", 64'(scr_we), 64'(0));
  endtask

  initial begin
    int w0;
    rst = 1'b1; frame = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_line = '0; rd_line = '0;
    ddram_busy = 1'b0; ddram_dout_ready = 1'b0; ddram_dout = '0; st_addr = '0; fb_din = '0;
    fill_mem(16'h0);

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    check("rst_ddram_rd", 64'(ddram_rd), 64'(0));
    check("rst_ddram_we", 64'(ddram_we), 64'(0));
    check("rst_fb_we", 64'(fb_we), 64'(0));
    check("rst_scr_we", 64'(scr_we), 64'(0));
    check("rst_wr_done", 64'(wr_done), 64'(0));
    check("rst_rd_done", 64'(rd_done), 64'(0));
    check("ddram_be", 64'(ddram_be), 64'(8'hFF));
    check("burstcnt", 64'(ddram_burstcnt), 64'(NW));
    check("ddram_clk", 64'(ddram_clk), 64'(clk));
    for (int s = 0; s < 4; s++) read_status(8'(s), "rst_status", 8'h00);

    // Write line 5 of bank 0, no back-pressure
    fill_mem(16'h0);
    do_write(5, 1'b0, 1'b0, 1'b1, 1'b1);
    read_status(8'd1, "st_wr_line", 8'd5);

    // Write with busy toggling every cycle, then stall count
    fill_mem(16'hA5C3);
    do_write(9, 1'b0, 1'b1, 1'b1, 1'b0);
    read_status(8'd3, "st_stall", 8'(stalls));

    // Read line 7 from the bank opposite frame=1
    read_request(7, 1'b1, 1'b1);
    feed_words(NW, 0, 1'b1);
    read_tail();
    read_status(8'd2, "st_rd_line", 8'd7);

    // Simultaneous requests: read completes before any write beat
    fill_mem(16'h3C00);
    frame = 1'b1; rd_line = 8'd3; wr_line = 8'd11; rd_req = 1'b1; wr_req = 1'b1;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    w0 = we_cycles;
    read_request(3, 1'b1, 1'b0);
    feed_words(NW, 0, 1'b1);
    check("rd_before_wr", 64'(we_cycles - w0), 64'(0));
    do_write(11, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall counter saturation, then reset drops ddram_we on the next edge
    fill_mem(16'h0F0F);
    ddram_busy = 1'b1; frame = 1'b0; wr_line = 8'd2; wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    for (int g = 0; g < 20 && !ddram_we; g++) step();
    check("we_rise", 64'(ddram_we), 64'(1));
    repeat (300) step();
    read_status(8'd3, "st_stall_sat", 8'hFF);
    rst = 1'b1;
    step();
    check("we_drop_rst", 64'(ddram_we), 64'(0));
    step();
    rst = 1'b0; ddram_busy = 1'b0;
    read_status(8'd3, "st_stall_rst", 8'(stalls));

    // Reset mid-read: in-flight words ignored, then a fresh read completes
    read_request(4, 1'b0, 1'b1);
    feed_words(40, 0, 1'b1);
    rst = 1'b1;
    feed_words(3, 40, 1'b0);
    rst = 1'b0;
    feed_words(85, 43, 1'b0);
    read_request(6, 1'b0, 1'b1);
    feed_words(NW, 0, 1'b1);
    read_tail();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
